// File: rtl/riscv_pkg.sv
// Shared pipeline types: hazard FSM states and the stage-control bundle
// driven by the hazard unit into the pipeline registers.
package riscv_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic id_ex_bubble;
        logic mem_wb_bubble;
        logic if_id_flush;
        logic id_ex_flush;
    } hz_ctrl_t;

    // Free-running pipeline: every register loads, nothing is squashed.
    localparam hz_ctrl_t CTRL_NORMAL = '{
        pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1, ex_mem_write: 1'b1,
        id_ex_bubble: 1'b0, mem_wb_bubble: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b0
    };

endpackage

// File: rtl/hazard_control_unit_if.sv
// Hazard-unit bundle: pipeline hazard inputs and the stall/flush/debug outputs.
interface hazard_control_unit_if #(parameter int CNT_W = 16) ();

    logic             mem_read_ex_i;
    logic [4:0]       rd_ex_i;
    logic [4:0]       rs_1_id_i;
    logic [4:0]       rs_2_id_i;
    logic             use_rs_1_id_i;
    logic             use_rs_2_id_i;
    logic             branch_taken_ex_i;
    logic             dmem_req_mem_i;
    logic             dmem_ack_i;
    logic             pc_write_o;
    logic             if_id_write_o;
    logic             id_ex_write_o;
    logic             ex_mem_write_o;
    logic             id_ex_bubble_o;
    logic             mem_wb_bubble_o;
    logic             if_id_flush_o;
    logic             id_ex_flush_o;
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output mem_read_ex_i, rd_ex_i, rs_1_id_i, rs_2_id_i, use_rs_1_id_i,
               use_rs_2_id_i, branch_taken_ex_i, dmem_req_mem_i, dmem_ack_i,
        input  pc_write_o, if_id_write_o, id_ex_write_o, ex_mem_write_o,
               id_ex_bubble_o, mem_wb_bubble_o, if_id_flush_o, id_ex_flush_o,
               err_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  mem_read_ex_i, rd_ex_i, rs_1_id_i, rs_2_id_i, use_rs_1_id_i,
               use_rs_2_id_i, branch_taken_ex_i, dmem_req_mem_i, dmem_ack_i,
        output pc_write_o, if_id_write_o, id_ex_write_o, ex_mem_write_o,
               id_ex_bubble_o, mem_wb_bubble_o, if_id_flush_o, id_ex_flush_o,
               err_o, stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller: load-use bubbles, dmem freeze with timeout watchdog,
// branch flushes, plus saturating debug counters.
module hazard_control_unit
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    hazard_control_unit_if.slave hz
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    hz_ctrl_t          ctrl;
    logic              freeze, load_use, stall_inc, flush_inc;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        freeze   = hz.dmem_req_mem_i && !hz.dmem_ack_i && (state_q != ERR);
        load_use = hz.mem_read_ex_i && (hz.rd_ex_i != REG_ZERO) &&
                   ((hz.use_rs_1_id_i && (hz.rs_1_id_i == hz.rd_ex_i)) ||
                    (hz.use_rs_2_id_i && (hz.rs_2_id_i == hz.rd_ex_i)));
        ctrl       = CTRL_NORMAL;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;

        if (state_q == ERR) begin
            ctrl      = '0;
            stall_inc = 1'b1;
        end else if (freeze) begin
            ctrl               = '0;
            ctrl.mem_wb_bubble = 1'b1;
            stall_inc          = 1'b1;
            if (state_q == RUN) begin
                state_d    = MEM_WAIT;
                wait_cnt_d = WAIT_W'(1);
            end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                state_d = ERR;
            end else begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end else begin
            // Release cycle of a wait also advances the pipeline normally.
            state_d    = RUN;
            wait_cnt_d = '0;
            if (hz.branch_taken_ex_i) begin
                ctrl.if_id_flush = 1'b1;
                ctrl.id_ex_flush = 1'b1;
                flush_inc        = 1'b1;
            end else if (load_use) begin
                ctrl.pc_write     = 1'b0;
                ctrl.if_id_write  = 1'b0;
                ctrl.id_ex_bubble = 1'b1;
                stall_inc         = 1'b1;
            end
        end
    end

    assign hz.pc_write_o      = ctrl.pc_write;
    assign hz.if_id_write_o   = ctrl.if_id_write;
    assign hz.id_ex_write_o   = ctrl.id_ex_write;
    assign hz.ex_mem_write_o  = ctrl.ex_mem_write;
    assign hz.id_ex_bubble_o  = ctrl.id_ex_bubble;
    assign hz.mem_wb_bubble_o = ctrl.mem_wb_bubble;
    assign hz.if_id_flush_o   = ctrl.if_id_flush;
    assign hz.id_ex_flush_o   = ctrl.id_ex_flush;
    assign hz.err_o           = (state_q == ERR);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc     (stall_inc),
        .cnt     (hz.stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc     (flush_inc),
        .cnt     (hz.flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench: directed vectors push expected controls/counters, a
// negedge monitor pops and compares against the DUT.
module tb_hazard_control_unit;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;

    // {pc, if_id_w, id_ex_w, ex_mem_w, id_ex_bub, mem_wb_bub, if_id_fl, id_ex_fl}
    localparam logic [7:0] NORM = 8'b1111_0000;
    localparam logic [7:0] LU   = 8'b0011_1000;
    localparam logic [7:0] FRZ  = 8'b0000_0100;
    localparam logic [7:0] FLU  = 8'b1111_0011;
    localparam logic [7:0] HALT = 8'b0000_0000;

    typedef struct {
        string            name;
        logic [7:0]       ctrl;
        logic             err;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t e;
    logic [7:0] got_ctrl;

    hazard_control_unit_if #(.CNT_W(CNT_W)) hz ();

    hazard_control_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .hz      (hz.slave)
    );

    always #5 clk = ~clk;

    assign got_ctrl = {hz.pc_write_o, hz.if_id_write_o, hz.id_ex_write_o, hz.ex_mem_write_o,
                       hz.id_ex_bubble_o, hz.mem_wb_bubble_o, hz.if_id_flush_o, hz.id_ex_flush_o};

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({got_ctrl, hz.err_o} !== {e.ctrl, e.err}) begin
                errors++;
                $display("FAIL %s ctrl/err: got %b/%b want %b/%b", e.name, got_ctrl, hz.err_o,
                         e.ctrl, e.err);
            end
            checks++;
            if ({hz.stall_cnt_o, hz.flush_cnt_o} !== {e.sc, e.fc}) begin
                errors++;
                $display("FAIL %s stall/flush cnt: got %0d/%0d want %0d/%0d", e.name,
                         hz.stall_cnt_o, hz.flush_cnt_o, e.sc, e.fc);
            end
        end
    end

    task automatic push(input string nm, input logic [7:0] c, input logic er,
                        input int sc, input int fc);
        exp_t x;
        x.name = nm; x.ctrl = c; x.err = er;
        x.sc = CNT_W'(sc); x.fc = CNT_W'(fc);
        sb.push_back(x);
    endtask

    task automatic drive(input logic mrd, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic br, input logic req, input logic ack);
        hz.mem_read_ex_i = mrd;  hz.rd_ex_i = rd;
        hz.rs_1_id_i = rs1;      hz.rs_2_id_i = rs2;
        hz.use_rs_1_id_i = u1;   hz.use_rs_2_id_i = u2;
        hz.branch_taken_ex_i = br;
        hz.dmem_req_mem_i = req; hz.dmem_ack_i = ack;
    endtask

    task automatic vec(input string nm, input logic mrd, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic br, input logic req, input logic ack,
                       input logic [7:0] c, input logic er, input int sc, input int fc);
        @(posedge clk); #1;
        drive(mrd, rd, rs1, rs2, u1, u2, br, req, ack);
        push(nm, c, er, sc, fc);
    endtask

    task automatic do_reset(input string nm);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(nm, NORM, 1'b0, 0, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset("reset");

        //   name          mrd rd rs1 rs2 u1 u2 br rq ak  ctrl err sc fc
        vec("idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 0);
        vec("lu_rs1",        1, 5, 5, 0, 1, 0, 0, 0, 0, LU,   0, 0, 0);
        vec("lu_advanced",   0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 1, 0);
        vec("lu_rd0",        1, 0, 0, 0, 1, 0, 0, 0, 0, NORM, 0, 1, 0);
        vec("rs2_unused",    1, 7, 3, 7, 1, 0, 0, 0, 0, NORM, 0, 1, 0);
        vec("lu_rs2",        1, 7, 3, 7, 1, 1, 0, 0, 0, LU,   0, 1, 0);
        vec("not_a_load",    0, 7, 7, 0, 1, 0, 0, 0, 0, NORM, 0, 2, 0);

        do_reset("reset_frz");
        vec("frz1",          0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 0, 0);
        vec("frz2",          0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 1, 0);
        vec("frz3",          0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 2, 0);
        vec("frz_ack",       0, 0, 0, 0, 0, 0, 0, 1, 1, NORM, 0, 3, 0);
        vec("after_ack",     0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 3, 0);
        vec("frz_over_lu",   1, 5, 5, 0, 1, 0, 0, 1, 0, FRZ,  0, 3, 0);
        vec("ack_then_lu",   1, 5, 5, 0, 1, 0, 0, 1, 1, LU,   0, 4, 0);
        vec("idle2",         0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 5, 0);
        vec("br_over_lu",    1, 5, 5, 0, 1, 0, 1, 0, 0, FLU,  0, 5, 0);
        vec("idle3",         0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 5, 1);
        vec("frz_br1",       0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ,  0, 5, 1);
        vec("frz_br2",       0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ,  0, 6, 1);
        vec("br_on_ack",     0, 0, 0, 0, 0, 0, 1, 1, 1, FLU,  0, 7, 1);
        vec("idle4",         0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 7, 2);
        vec("frz_x",         0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 7, 2);
        vec("req_drop",      0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 8, 2);
        vec("frz_mid",       0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 8, 2);

        do_reset("reset_mid_wait");
        vec("stale_ack",     0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, 0, 0, 0);

        // Watchdog: four frozen cycles, then ERR absorbs everything.
        vec("to_w1",         0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 0, 0);
        vec("to_w2",         0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 1, 0);
        vec("to_w3",         0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 2, 0);
        vec("to_w4",         0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 3, 0);
        for (int i = 0; i < 14; i++) begin
            vec("err_hold", 1, 5, 5, 0, 1, 0, 1, 1'(i % 2), 1'(1 - i % 2), HALT, 1,
                (4 + i > 15) ? 15 : 4 + i, 0);
        end
        do_reset("reset_err");
        vec("after_err",     0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 0);
        vec("lu_after_err",  1, 9, 0, 9, 0, 1, 0, 0, 0, LU,   0, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
